// File: rtl/onewire_master.sv
// Single-drop 1-Wire master: reset/presence, one command byte out, one byte in.
// Open-drain line; all timing is counter-driven from the system clock.
module onewire_master #(
    parameter logic [7:0]  CMD    = 8'hCC,
    parameter logic [31:0] T_RSTL = 32'd48000,
    parameter logic [31:0] T_RSTH = 32'd48000,
    parameter logic [31:0] T_PSMP = 32'd7000,
    parameter logic [31:0] T_SLOT = 32'd7000,
    parameter logic [31:0] T_LOW1 = 32'd600,
    parameter logic [31:0] T_LOW0 = 32'd6000,
    parameter logic [31:0] T_RSMP = 32'd1300,
    parameter logic [31:0] T_REC  = 32'd200
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        port,
    output logic [7:0] flagbyte,
    output logic       idata,
    output logic [7:0] rdbyte
);

    typedef enum logic [2:0] {
        S_INIT_LOW,
        S_INIT_REL,
        S_WR,
        S_REC,
        S_RD,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nstate;
    logic [31:0] r_cnt;
    logic [2:0]  r_bit;
    logic        r_rd;
    logic        r_pres;
    logic        r_idata;
    logic [7:0]  r_rdbyte;
    logic [1:0]  r_sync;
    logic        w_line;
    logic [31:0] w_low;
    logic        w_drv;
    logic        w_drv_low;
    logic        w_com;
    logic        w_init;
    logic        w_busy;
    logic        w_last;

    assign w_line = r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= (w_nstate != r_state) ? '0 : r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_INIT_LOW: if (r_cnt == T_RSTL - 32'd1) w_nstate = S_INIT_REL;
            S_INIT_REL: if (r_cnt == T_RSTH - 32'd1)
                w_nstate = r_pres ? S_WR : S_DONE;
            S_WR:       if (r_cnt == T_SLOT - 32'd1) w_nstate = S_REC;
            S_RD:       if (r_cnt == T_SLOT - 32'd1) w_nstate = S_REC;
            S_REC: begin
                if (r_cnt == T_REC - 32'd1) begin
                    if (r_bit != 3'd7)
                        w_nstate = r_rd ? S_RD : S_WR;
                    else
                        w_nstate = r_rd ? S_DONE : S_RD;
                end
            end
            S_DONE:     w_nstate = S_DONE;
            default:    w_nstate = S_INIT_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= 2'b11;
            r_bit    <= '0;
            r_rd     <= 1'b0;
            r_pres   <= 1'b0;
            r_idata  <= 1'b0;
            r_rdbyte <= '0;
        end else begin
            r_sync <= {r_sync[0], port};
            if (r_state == S_INIT_REL && r_cnt == T_PSMP)
                r_pres <= ~w_line;
            if (r_state == S_RD && r_cnt == T_RSMP) begin
                r_idata         <= w_line;
                r_rdbyte[r_bit] <= w_line;
            end
            // Leaving recovery advances the bit; after bit 7 switch to reads
            if (r_state == S_REC && w_nstate != S_REC) begin
                if (r_bit == 3'd7) begin
                    r_bit <= '0;
                    r_rd  <= 1'b1;
                end else begin
                    r_bit <= r_bit + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_low = CMD[r_bit] ? T_LOW1 : T_LOW0;
        w_drv = 1'b0;
        unique case (r_state)
            S_INIT_LOW: w_drv = 1'b1;
            S_WR:       w_drv = (r_cnt < w_low);
            S_RD:       w_drv = (r_cnt < T_LOW1);
            default:    w_drv = 1'b0;
        endcase
        // Gating with the raw reset releases the line the instant reset asserts
        w_drv_low = w_drv & reset;
        w_com     = (r_state == S_WR) || (r_state == S_REC) || (r_state == S_RD);
        w_init    = (r_state == S_INIT_LOW) || (r_state == S_INIT_REL);
        w_busy    = (r_state != S_DONE);
        w_last    = (r_state == S_DONE);
        flagbyte  = reset ? {w_drv_low, w_busy, w_com, w_init, r_pres,
                             w_com & r_rd, w_com & ~r_rd, w_last} : 8'h00;
    end

    assign port   = w_drv_low ? 1'b0 : 1'bz;
    assign idata  = r_idata;
    assign rdbyte = r_rdbyte;

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master: scaled timing, bus slave model, pulse scoreboard.
// Expected pulses/flags are derived from the protocol timeline, not the RTL.
module tb_onewire_master;

    localparam int RSTL = 480;
    localparam int RSTH = 480;
    localparam int PSMP = 70;
    localparam int SLOT = 70;
    localparam int LOW1 = 6;
    localparam int LOW0 = 60;
    localparam int RSMP = 13;
    localparam int REC  = 2;
    localparam int SP   = SLOT + REC;
    localparam logic [7:0] CMDB = 8'hCC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sl_low = 1'b0;
    wire        port;
    logic [7:0] flagbyte;
    logic [7:0] rdbyte;
    logic       idata;

    pullup (port);
    assign port = sl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    onewire_master #(
        .CMD(CMDB),
        .T_RSTL(32'(RSTL)), .T_RSTH(32'(RSTH)), .T_PSMP(32'(PSMP)),
        .T_SLOT(32'(SLOT)), .T_LOW1(32'(LOW1)), .T_LOW0(32'(LOW0)),
        .T_RSMP(32'(RSMP)), .T_REC(32'(REC))
    ) dut (
        .clk(clk), .reset(reset), .port(port),
        .flagbyte(flagbyte), .idata(idata), .rdbyte(rdbyte)
    );

    typedef struct {
        int         start;
        int         len;
        logic [7:0] flags;
        bit         is_rd;
        logic       rbit;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n = -1;
    bit   abort = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h n=%0d", nm, act, exp, n);
        end
    endtask

    // Monitor: pops one expectation per master low pulse
    initial begin : mon
        bit         inp;
        bit         have;
        int         st;
        int         rd_at;
        int         fl_at;
        logic       rb;
        exp_t       e;
        inp = 0; have = 0; st = 0; rd_at = -1; fl_at = -1; rb = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n = -1; inp = 0; have = 0; rd_at = -1; fl_at = -1;
            end else begin
                n++;
                if (flagbyte[7]) chk("drv_port_low", 32'(port), 0);
                else if (!sl_low) chk("released_port", 32'(port), 1);
                if (flagbyte[7] && !inp) begin
                    inp = 1; st = n;
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse at n=%0d", n);
                    end else begin
                        e = sb_q.pop_front(); have = 1;
                        chk("pulse_start", st, e.start);
                        fl_at = n + 1;
                    end
                end
                if (have && n == fl_at) chk("slot_flags", 32'(flagbyte), 32'(e.flags));
                if (!flagbyte[7] && inp) begin
                    inp = 0;
                    if (have) begin
                        chk("pulse_len", n - st, e.len);
                        if (e.is_rd) begin rd_at = st + 20; rb = e.rbit; end
                    end
                    have = 0;
                end
                if (n == rd_at) chk("read_bit", 32'(idata), 32'(rb));
            end
        end
    end

    task automatic wait_port(input logic v, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (abort) return;
            if (port === v) begin ok = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic fall(input string nm, output bit ok);
        bit a;
        wait_port(1'b1, a);
        if (a) wait_port(1'b0, a);
        ok = a;
        if (!a && !abort) begin
            checks++; errors++;
            $display("FAIL %s timeout n=%0d", nm, n);
        end
    endtask

    task automatic set_low(input logic v);
        #2 sl_low = v;
    endtask

    // Slave: presence pulse, samples write slots, answers read slots
    task automatic slave(input bit present, input logic [7:0] pat);
        bit         ok;
        logic [7:0] seen;
        int         d;
        int         h;
        seen = '0;
        if (!present) return;
        wait_port(1'b0, ok);
        if (ok) wait_port(1'b1, ok);
        if (!ok) begin
            if (!abort) begin checks++; errors++; $display("FAIL reset_pulse timeout"); end
            return;
        end
        d = $urandom_range(15, 50);
        h = $urandom_range(60, 240);
        repeat (d) @(negedge clk);
        set_low(1'b1);
        repeat (h) @(negedge clk);
        set_low(1'b0);
        for (int i = 0; i < 8; i++) begin
            fall("wr_fall", ok);
            if (!ok) return;
            repeat (20) @(negedge clk);
            seen[i] = port;
        end
        chk("slave_cmd", 32'(seen), 32'(CMDB));
        for (int j = 0; j < 8; j++) begin
            fall("rd_fall", ok);
            if (!ok) return;
            if (!pat[j]) begin
                set_low(1'b1);
                repeat (25) @(negedge clk);
                set_low(1'b0);
            end
        end
    endtask

    task automatic build(input bit present, input logic [7:0] pat,
                         output int dn, output logic [7:0] dfl,
                         output logic [7:0] pfl);
        exp_t       e;
        logic [7:0] c;
        c = CMDB;
        sb_q.delete();
        e.start = 0; e.len = RSTL; e.flags = 8'hD0; e.is_rd = 0; e.rbit = 0;
        sb_q.push_back(e);
        if (!present) begin
            dn = RSTL + RSTH; dfl = 8'h01; pfl = 8'h50;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            e.start = RSTL + RSTH + k * SP;
            if (k < 8) begin
                e.len = c[k] ? LOW1 : LOW0; e.flags = 8'hEA;
                e.is_rd = 0; e.rbit = 0;
            end else begin
                e.len = LOW1; e.flags = 8'hEC;
                e.is_rd = 1; e.rbit = pat[k-8];
            end
            sb_q.push_back(e);
        end
        dn = RSTL + RSTH + 16 * SP; dfl = 8'h09; pfl = 8'h6C;
    endtask

    task automatic wait_n(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (n == target) begin ok = 1; return; end
        end
        checks++; errors++;
        $display("FAIL wait_n timeout target=%0d n=%0d", target, n);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input bit present, input logic [7:0] pat);
        int         dn;
        logic [7:0] dfl;
        logic [7:0] pfl;
        bit         ok;
        build(present, pat, dn, dfl, pfl);
        fork
            slave(present, pat);
            begin
                @(posedge clk); #1 reset = 1'b1;
                wait_n(dn - 1, ok);
                if (ok) begin
                    chk("pre_done_flags", 32'(flagbyte), 32'(pfl));
                    @(negedge clk); #1;
                    chk("done_flags", 32'(flagbyte), 32'(dfl));
                    if (present) begin
                        chk("rdbyte", 32'(rdbyte), 32'(pat));
                        chk("idata_last", 32'(idata), 32'(pat[7]));
                    end
                    chk("queue_empty", sb_q.size(), 0);
                end
            end
        join
    endtask

    task automatic run_abort(input logic [7:0] pat);
        int         dn;
        logic [7:0] dfl;
        logic [7:0] pfl;
        bit         ok;
        build(1'b1, pat, dn, dfl, pfl);
        fork
            slave(1'b1, pat);
            begin
                @(posedge clk); #1 reset = 1'b1;
                wait_n(RSTL + RSTH + 3 * SP + 3, ok);
                chk("pre_abort_drv", 32'(flagbyte[7]), 1);
                abort = 1'b1;
                #2 reset = 1'b0;
                #1;
                chk("abort_port", 32'(port), 1);
                chk("abort_flags", 32'(flagbyte), 0);
                chk("abort_idata", 32'(idata), 0);
            end
        join
        abort = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'(flagbyte), 0);
        chk("rst_idata", 32'(idata), 0);
        chk("rst_port", 32'(port), 1);
        chk("rst_rdbyte", 32'(rdbyte), 0);
        run(1'b0, 8'h00);
        do_reset();
        run(1'b1, 8'hFF);
        do_reset();
        run(1'b1, 8'h00);
        for (int r = 0; r < 2; r++) begin
            do_reset();
            run(1'b1, 8'($urandom));
        end
        do_reset();
        run_abort(8'($urandom));
        run(1'b1, 8'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
